wave_phase_gen: RTL and testbench
=================================

Name: wave_phase_gen

Overview:
- Numerically controlled phase accumulator (NCO front end); sits directly upstream of the quarter-wave sine ROM lookup stage.
- Produces the DEPTH-entry table phase index it consumes.
- Supports fixed-frequency tones and linear frequency sweeps (chirp), with phase offset, phase sync and a valid/ready config handshake.
- Output is registered and one sample per i_en strobe.

Parameters:
- ACC_WIDTH, 32, phase accumulator and tuning-word width.
- DEPTH, 1024, sine table depth (power of 2, >= 8). PW = $clog2(DEPTH) is the phase index width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  sample strobe; one accumulator step per high cycle.
- i_cfg_valid  in  1  config request.
- o_cfg_ready  out  1  config can be accepted.
- i_cfg_mode  in  1  0 = fixed tone, 1 = sweep.
- i_cfg_ftw  in  ACC_WIDTH  start frequency tuning word.
- i_cfg_step  in  ACC_WIDTH  unsigned FTW increment per sample (sweep only).
- i_cfg_stop  in  ACC_WIDTH  final FTW (sweep only).
- i_phase_offset  in  PW  added to output index; sampled each cycle.
- i_sync  in  1  synchronous accumulator clear.
- i_halt  in  1  return to IDLE.
- o_phase_count  out  PW  table phase index.
- o_valid  out  1  o_phase_count holds a new sample.
- o_sweep_done  out  1  one-cycle pulse when sweep reaches i_cfg_stop.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, acc=0, ftw/step/stop regs=0, o_phase_count=0, o_valid=0, o_sweep_done=0, o_busy=0, o_cfg_ready=1.
- States: IDLE, RUN_FIXED, RUN_SWEEP, HOLD.
- o_cfg_ready=1 in IDLE, RUN_FIXED and HOLD; 0 in RUN_SWEEP.
- Config accept = i_cfg_valid & o_cfg_ready. It latches ftw, step and stop.
  - mode0 -> RUN_FIXED.
  - mode1 with i_cfg_ftw < i_cfg_stop -> RUN_SWEEP.
  - mode1 with i_cfg_ftw >= i_cfg_stop -> HOLD, ftw<=i_cfg_stop, o_sweep_done=1 next cycle.
- acc is never cleared by config, so retuning is phase-continuous.
- Step (i_en=1, state != IDLE):
  - acc_new = (acc + ftw) mod 2^ACC_WIDTH.
  - Registered next cycle: o_phase_count = (acc_new[ACC_WIDTH-1 -: PW] + i_phase_offset) mod 2^PW, and o_valid=1.
  - o_valid=0 on any cycle without a step.
  - Latency is 1 cycle from i_en to o_valid.
- Sweep: on each step in RUN_SWEEP, sum = ftw + step computed at ACC_WIDTH+1 bits.
  - sum >= stop: ftw<=stop, state->HOLD, o_sweep_done=1 for one cycle coincident with that sample's o_valid.
  - Otherwise ftw<=sum.
  - The current step always uses the pre-update ftw.
- HOLD behaves exactly as RUN_FIXED with ftw=stop.
- i_sync=1: acc<=0 and takes priority over the step. If i_en is high in the same cycle, the emitted sample uses acc_new=0, so output = i_phase_offset. Sweep ftw is not affected.
- Config accept coincident with a step: the step uses the old ftw; the new ftw applies from the next step. In IDLE, i_en in the accept cycle produces no sample.
- i_halt=1: state->IDLE next cycle and no step in that cycle. acc and ftw are held, o_valid=0. Priority: reset > i_halt > config accept.
- i_en while IDLE: ignored, acc held.
- Reset mid-operation: all outputs clear immediately (asynchronously); the sweep is abandoned.
- o_busy = (state != IDLE), registered.

Test Plan:
- Reset, then cfg mode0 ftw=0x0040_0000, offset=0, five i_en pulses -> o_phase_count 1,2,3,4,5. Each o_valid is 1 cycle after its i_en, and o_valid=0 between pulses.
- Wrap: cfg mode0 ftw=0x4000_0000, five steps -> 256,512,768,0,256. Then offset=1000 with ftw=0x0040_0000 starting from acc=0 (after sync) -> 1001, ..., 1023, 0, 1.
- Sweep: ftw=0x0040_0000, step=0x0040_0000, stop=0x0100_0000 -> phases 1,3,6; o_sweep_done high with the 3rd sample; o_cfg_ready 0 then 1; 4th step -> 10 (HOLD, ftw=4).
- Degenerate sweep: mode1 ftw=0x0200_0000, stop=0x0100_0000 -> HOLD, o_sweep_done pulse the cycle after accept, steps advance by 4.
- i_sync+i_en in the same cycle mid-run with offset=7 -> o_phase_count=7. A retune via cfg accept coincident with i_en -> that sample uses the old ftw.
- Assert i_rst_n=0 mid-sweep between clock edges -> o_phase_count, o_valid, o_busy and o_sweep_done are 0 immediately; o_cfg_ready=1. i_halt mid-run -> o_valid stops, and restarting with the same ftw continues from the held phase.

Source files
------------

// File: rtl/wave_phase_gen.sv
// Phase accumulator (NCO front end) producing the sine-table phase index.
// Supports fixed tones, linear FTW sweeps, phase offset/sync and halt.
module wave_phase_gen #(
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned DEPTH     = 1024,
   localparam int unsigned PW       = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_cfg_valid,
   output logic                 o_cfg_ready,
   input  logic                 i_cfg_mode,
   input  logic [ACC_WIDTH-1:0] i_cfg_ftw,
   input  logic [ACC_WIDTH-1:0] i_cfg_step,
   input  logic [ACC_WIDTH-1:0] i_cfg_stop,
   input  logic [PW-1:0]        i_phase_offset,
   input  logic                 i_sync,
   input  logic                 i_halt,
   output logic [PW-1:0]        o_phase_count,
   output logic                 o_valid,
   output logic                 o_sweep_done,
   output logic                 o_busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN_FIXED = 2'd1,
      RUN_SWEEP = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] ftw_q, ftw_d;
   logic [ACC_WIDTH-1:0] step_q, step_d;
   logic [ACC_WIDTH-1:0] stop_q, stop_d;
   logic [PW-1:0]        phase_d;
   logic                 valid_d;
   logic                 done_d;
   logic                 busy_d;
   logic                 ready_d;

   logic                 do_step;
   logic                 cfg_accept;
   logic [ACC_WIDTH-1:0] acc_step;
   logic [ACC_WIDTH:0]   sweep_sum;

   // Halt wins over config; a step needs an active state.
   assign do_step    = i_en && (state_q != IDLE) && !i_halt;
   assign cfg_accept = i_cfg_valid && o_cfg_ready && !i_halt;

   // Sync zeroes the value the step lands on, so the sample shows only the offset.
   assign acc_step  = i_sync ? '0 : acc_q + ftw_q;
   // One extra bit so the end-of-sweep test cannot be fooled by wraparound.
   assign sweep_sum = {1'b0, ftw_q} + {1'b0, step_q};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a variable unassigned and infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      ftw_d   = ftw_q;
      step_d  = step_q;
      stop_d  = stop_q;
      phase_d = o_phase_count;
      valid_d = 1'b0;
      done_d  = 1'b0;

      if (i_halt) begin
         state_d = IDLE;
      end else begin
         if (do_step) begin
            acc_d   = acc_step;
            phase_d = acc_step[ACC_WIDTH-1 -: PW] + i_phase_offset;
            valid_d = 1'b1;
            if (state_q == RUN_SWEEP) begin
               if (sweep_sum >= {1'b0, stop_q}) begin
                  ftw_d   = stop_q;
                  state_d = HOLD;
                  done_d  = 1'b1;
               end else begin
                  ftw_d = sweep_sum[ACC_WIDTH-1:0];
               end
            end
         end else if (i_sync) begin
            acc_d = '0;
         end

         // Accept is never possible in RUN_SWEEP, so it cannot collide with a sweep update.
         // The accumulator is left alone so retuning stays phase-continuous.
         if (cfg_accept) begin
            step_d = i_cfg_step;
            stop_d = i_cfg_stop;
            if (!i_cfg_mode) begin
               ftw_d   = i_cfg_ftw;
               state_d = RUN_FIXED;
            end else if (i_cfg_ftw < i_cfg_stop) begin
               ftw_d   = i_cfg_ftw;
               state_d = RUN_SWEEP;
            end else begin
               ftw_d   = i_cfg_stop;
               state_d = HOLD;
               done_d  = 1'b1;
            end
         end
      end

      busy_d  = (state_d != IDLE);
      ready_d = (state_d != RUN_SWEEP);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         ftw_q         <= '0;
         step_q        <= '0;
         stop_q        <= '0;
         o_phase_count <= '0;
         o_valid       <= 1'b0;
         o_sweep_done  <= 1'b0;
         o_busy        <= 1'b0;
         o_cfg_ready   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every register update from the
         // same pre-edge values, independent of statement order.
         state_q       <= state_d;
         acc_q         <= acc_d;
         ftw_q         <= ftw_d;
         step_q        <= step_d;
         stop_q        <= stop_d;
         o_phase_count <= phase_d;
         o_valid       <= valid_d;
         o_sweep_done  <= done_d;
         o_busy        <= busy_d;
         o_cfg_ready   <= ready_d;
      end
   end

endmodule

// File: tb/tb_wave_phase_gen.sv
// Self-checking bench for wave_phase_gen: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_wave_phase_gen;

   localparam int unsigned ACC_W = 32;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned PW    = 10;
   localparam longint unsigned MOD = 64'd1 << ACC_W;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_en = 1'b0;
   logic             i_cfg_valid = 1'b0;
   logic             o_cfg_ready;
   logic             i_cfg_mode = 1'b0;
   logic [ACC_W-1:0] i_cfg_ftw = '0;
   logic [ACC_W-1:0] i_cfg_step = '0;
   logic [ACC_W-1:0] i_cfg_stop = '0;
   logic [PW-1:0]    i_phase_offset = '0;
   logic             i_sync = 1'b0;
   logic             i_halt = 1'b0;
   logic [PW-1:0]    o_phase_count;
   logic             o_valid;
   logic             o_sweep_done;
   logic             o_busy;

   wave_phase_gen #(.ACC_WIDTH(ACC_W), .DEPTH(DEPTH)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_en           (i_en),
      .i_cfg_valid    (i_cfg_valid),
      .o_cfg_ready    (o_cfg_ready),
      .i_cfg_mode     (i_cfg_mode),
      .i_cfg_ftw      (i_cfg_ftw),
      .i_cfg_step     (i_cfg_step),
      .i_cfg_stop     (i_cfg_stop),
      .i_phase_offset (i_phase_offset),
      .i_sync         (i_sync),
      .i_halt         (i_halt),
      .o_phase_count  (o_phase_count),
      .o_valid        (o_valid),
      .o_sweep_done   (o_sweep_done),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint unsigned m_acc, m_ftw, m_inc, m_stop;
   longint unsigned m_phase;
   bit m_valid, m_done, m_on, m_sweeping;

   task automatic model_reset();
      m_acc = 0; m_ftw = 0; m_inc = 0; m_stop = 0;
      m_phase = 0; m_valid = 0; m_done = 0; m_on = 0; m_sweeping = 0;
   endtask

   task automatic model_clock();
      longint unsigned nxt;
      bit stepping = i_en && m_on && !i_halt;
      bit taking   = i_cfg_valid && !m_sweeping && !i_halt;
      m_valid = 0;
      m_done  = 0;
      if (i_halt) begin
         m_on = 0;
         m_sweeping = 0;
         return;
      end
      if (stepping) begin
         nxt     = i_sync ? 64'd0 : (m_acc + m_ftw) % MOD;
         m_acc   = nxt;
         m_phase = ((nxt >> (ACC_W - PW)) + longint'(i_phase_offset)) % DEPTH;
         m_valid = 1;
         if (m_sweeping) begin
            if (m_ftw + m_inc >= m_stop) begin
               m_ftw = m_stop; m_sweeping = 0; m_done = 1;
            end else begin
               m_ftw = m_ftw + m_inc;
            end
         end
      end else if (i_sync) begin
         m_acc = 0;
      end
      if (taking) begin
         m_inc = i_cfg_step;
         m_stop = i_cfg_stop;
         m_on = 1;
         if (!i_cfg_mode) begin
            m_ftw = i_cfg_ftw; m_sweeping = 0;
         end else if (i_cfg_ftw < i_cfg_stop) begin
            m_ftw = i_cfg_ftw; m_sweeping = 1;
         end else begin
            m_ftw = i_cfg_stop; m_sweeping = 0; m_done = 1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge i_clk or negedge i_rst_n);
         if (!i_rst_n) model_reset();
         else model_clock();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge i_clk);
      if (chk_on) begin
         check("valid", 64'(o_valid), 64'(m_valid));
         check("sweep_done", 64'(o_sweep_done), 64'(m_done));
         check("busy", 64'(o_busy), 64'(m_on));
         check("cfg_ready", 64'(o_cfg_ready), 64'(!m_sweeping));
         if (m_valid) check("phase", 64'(o_phase_count), m_phase);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge i_clk);
   endtask

   task automatic lit_phase(input string name, input longint unsigned exp);
      check({name, "_dut"}, 64'(o_phase_count), exp);
      check({name, "_model"}, m_phase, exp);
   endtask

   task automatic step_chk(input string name, input longint unsigned exp);
      i_en = 1'b1;
      cyc();
      i_en = 1'b0;
      check({name, "_valid"}, 64'(o_valid), 64'd1);
      lit_phase(name, exp);
   endtask

   task automatic cfg(input logic mode, input logic [ACC_W-1:0] ftw,
                      input logic [ACC_W-1:0] stp, input logic [ACC_W-1:0] stop);
      i_cfg_mode = mode; i_cfg_ftw = ftw; i_cfg_step = stp; i_cfg_stop = stop;
      i_cfg_valid = 1'b1;
      cyc();
      i_cfg_valid = 1'b0;
   endtask

   task automatic sync();
      i_sync = 1'b1;
      cyc();
      i_sync = 1'b0;
   endtask

   initial begin
      @(negedge i_clk);
      cyc();
      check("rst_phase", 64'(o_phase_count), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_ready", 64'(o_cfg_ready), 64'd1);
      i_rst_n = 1'b1;
      chk_on = 1'b1;
      cyc();

      // Fixed tone, isolated pulses.
      cfg(1'b0, 32'h0040_0000, '0, '0);
      for (int k = 1; k <= 5; k++) begin
         step_chk("tone", 64'(k));
         cyc();
         check("tone_gap_valid", 64'(o_valid), 64'd0);
      end

      // Index wrap, then offset wrap.
      sync();
      cfg(1'b0, 32'h4000_0000, '0, '0);
      step_chk("wrap1", 256);
      step_chk("wrap2", 512);
      step_chk("wrap3", 768);
      step_chk("wrap4", 0);
      step_chk("wrap5", 256);
      sync();
      cfg(1'b0, 32'h0040_0000, '0, '0);
      i_phase_offset = 10'd1000;
      for (int k = 1; k <= 25; k++) step_chk("offset", 64'((k + 1000) % 1024));
      i_phase_offset = '0;

      // Sweep 1 -> 4 units with step 1.
      sync();
      cfg(1'b1, 32'h0040_0000, 32'h0040_0000, 32'h0100_0000);
      check("sweep_ready0", 64'(o_cfg_ready), 64'd0);
      step_chk("sweep1", 1);
      step_chk("sweep2", 3);
      step_chk("sweep3", 6);
      check("sweep_done", 64'(o_sweep_done), 64'd1);
      cyc();
      check("sweep_ready1", 64'(o_cfg_ready), 64'd1);
      step_chk("sweep_hold", 10);

      // Degenerate sweep goes straight to HOLD with ftw = stop.
      sync();
      cfg(1'b1, 32'h0200_0000, 32'h0, 32'h0100_0000);
      check("degen_done", 64'(o_sweep_done), 64'd1);
      check("degen_busy", 64'(o_busy), 64'd1);
      step_chk("degen1", 4);
      step_chk("degen2", 8);

      // Sync coincident with a step, then retune coincident with a step.
      i_phase_offset = 10'd7;
      i_sync = 1'b1;
      step_chk("sync_en", 7);
      i_sync = 1'b0;
      i_cfg_mode = 1'b0; i_cfg_ftw = 32'h0080_0000; i_cfg_valid = 1'b1;
      step_chk("retune_old", 11);
      i_cfg_valid = 1'b0;
      step_chk("retune_new", 13);
      i_phase_offset = '0;

      // Asynchronous reset mid-sweep.
      sync();
      cfg(1'b1, 32'h0040_0000, 32'h0000_1000, 32'hF000_0000);
      step_chk("pre_rst", 1);
      i_en = 1'b1;
      @(posedge i_clk);
      #2;
      i_en = 1'b0;
      i_rst_n = 1'b0;
      #1;
      check("arst_phase", 64'(o_phase_count), 64'd0);
      check("arst_valid", 64'(o_valid), 64'd0);
      check("arst_busy", 64'(o_busy), 64'd0);
      check("arst_done", 64'(o_sweep_done), 64'd0);
      check("arst_ready", 64'(o_cfg_ready), 64'd1);
      cyc();
      i_rst_n = 1'b1;
      cyc();

      // Halt, ignored enable while idle, phase-continuous restart.
      cfg(1'b0, 32'h0040_0000, '0, '0);
      step_chk("halt_a", 1);
      step_chk("halt_b", 2);
      step_chk("halt_c", 3);
      i_halt = 1'b1; i_en = 1'b1;
      cyc();
      i_halt = 1'b0; i_en = 1'b0;
      check("halt_valid", 64'(o_valid), 64'd0);
      check("halt_busy", 64'(o_busy), 64'd0);
      i_en = 1'b1;
      cyc();
      i_en = 1'b0;
      check("idle_en_valid", 64'(o_valid), 64'd0);
      cfg(1'b0, 32'h0040_0000, '0, '0);
      step_chk("resume", 4);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         i_en           = 1'($urandom_range(0, 1));
         i_sync         = ($urandom_range(0, 19) == 0);
         i_halt         = ($urandom_range(0, 39) == 0);
         i_cfg_valid    = ($urandom_range(0, 7) == 0);
         i_cfg_mode     = 1'($urandom_range(0, 1));
         i_cfg_ftw      = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0400_0000);
         i_cfg_step     = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0080_0000);
         i_cfg_stop     = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 32'h0800_0000);
         i_phase_offset = PW'($urandom_range(0, DEPTH - 1));
         i_rst_n        = ($urandom_range(0, 999) != 0);
         cyc();
      end
      i_en = 1'b0; i_sync = 1'b0; i_halt = 1'b0; i_cfg_valid = 1'b0; i_rst_n = 1'b1;
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
